spectrum_frame_buffer: RTL and testbench

- Captures the FFT modulus stream (sop/eop/valid) and scales each bin to a display bar height.
- Holds the heights in ping-pong frame banks, so the HDMI renderer always reads a complete, stable spectrum.
- Adds selectable linear/log scaling, a peak-hold array with timed decay, a freeze control and frame-error detection.
- Sits between fft_top and hdmi_top.

---
 rtl/spectrum_frame_buffer_pkg.sv | 38 +++
 rtl/spectrum_frame_buffer_if.sv | 25 ++
 rtl/spectrum_frame_buffer_height_calc.sv | 54 +++++
 rtl/spectrum_frame_buffer.sv | 247 ++++++++++++++++++++++++
 tb/tb_spectrum_frame_buffer.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/spectrum_frame_buffer_pkg.sv
// Shared types and helpers for the spectrum frame buffer: FSM states,
// a constant clog2, and the bar-height saturate / log-gain functions.
package spec_fb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

  function automatic logic [15:0] sat_height(input logic [31:0] value,
                                             input logic [15:0] max_h);
    return (value > {16'd0, max_h}) ? max_h : value[15:0];
  endfunction

  // Height grows by 'gain' per octave; a zero bin is drawn as an empty bar.
  function automatic logic [15:0] log_height(input logic        is_zero,
                                             input logic [7:0]  msb,
                                             input logic [15:0] gain,
                                             input logic [15:0] max_h);
    logic [31:0] prod;
    prod = ({24'd0, msb} + 32'd1) * {16'd0, gain};
    return is_zero ? 16'd0 : sat_height(prod, max_h);
  endfunction

endpackage

// File: rtl/spectrum_frame_buffer_if.sv
// FFT modulus stream plus the display read port of the spectrum frame buffer.
interface spectrum_frame_buffer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9,
  parameter int BAR_W  = 11
);
  logic              fft_sop;
  logic              fft_eop;
  logic              fft_valid;
  logic [DATA_W-1:0] fft_data;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_en;
  logic [BAR_W-1:0]  rd_data;
  logic [BAR_W-1:0]  rd_peak;

  modport master (
    output fft_sop, fft_eop, fft_valid, fft_data, rd_addr, rd_en,
    input  rd_data, rd_peak
  );

  modport slave (
    input  fft_sop, fft_eop, fft_valid, fft_data, rd_addr, rd_en,
    output rd_data, rd_peak
  );
endinterface

// File: rtl/spectrum_frame_buffer_height_calc.sv
// One-stage bin-to-bar scaling: the leading-one position and the saturated
// linear value are registered, the log gain is applied on the register output.
module spec_height_calc
  import spec_fb_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int BAR_W     = 11,
  parameter int MAX_H     = 720,
  parameter int LIN_SHIFT = 12,
  parameter int LOG_GAIN  = 22
) (
  input  logic              sys_clk,
  input  logic              sys_rstn,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_log,
  output logic [BAR_W-1:0]  out_height
);

  localparam int MSB_W = clog2(DATA_W);

  logic             log_d, log_q;
  logic             zero_d, zero_q;
  logic [MSB_W-1:0] msb_d, msb_q;
  logic [BAR_W-1:0] lin_d, lin_q;

  always_comb begin
    log_d  = in_log;
    zero_d = (in_data == '0);
    msb_d  = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (in_data[i]) msb_d = MSB_W'(i);
    end
    lin_d = BAR_W'(sat_height(32'(in_data >> LIN_SHIFT), 16'(MAX_H)));
  end

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      log_q  <= 1'b0;
      zero_q <= 1'b1;
      msb_q  <= '0;
      lin_q  <= '0;
    end else begin
      log_q  <= log_d;
      zero_q <= zero_d;
      msb_q  <= msb_d;
      lin_q  <= lin_d;
    end
  end

  assign out_height = log_q
    ? BAR_W'(log_height(zero_q, 8'(msb_q), 16'(LOG_GAIN), 16'(MAX_H)))
    : lin_q;

endmodule

// File: rtl/spectrum_frame_buffer.sv
// Captures FFT modulus frames into ping-pong bar-height banks with a decaying
// peak-hold array; the display always reads the last complete, accepted frame.
module spectrum_frame_buffer
  import spec_fb_pkg::*;
#(
  parameter int FFT_LEN      = 1024,
  parameter int N_BINS       = FFT_LEN / 2,
  parameter int DATA_W       = 32,
  parameter int BAR_W        = 11,
  parameter int MAX_H        = 720,
  parameter int LIN_SHIFT    = 12,
  parameter int LOG_GAIN     = 22,
  parameter int DECAY_FRAMES = 4,
  parameter int DECAY_STEP   = 8
) (
  input  logic                    sys_clk,
  input  logic                    sys_rstn,
  input  logic                    log_mode,
  input  logic                    freeze,
  spectrum_frame_buffer_if.slave  bus,
  output logic                    frame_done,
  output logic                    frame_err,
  output logic [15:0]             frame_cnt
);

  localparam int IDX_W  = clog2(FFT_LEN);
  localparam int ADDR_W = clog2(N_BINS);
  localparam int DCNT_W = clog2(DECAY_FRAMES + 1);

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                log_q, log_d;
  logic                err_q, err_d;
  logic                done_q, done_d;
  logic                commit_q, commit_d;
  logic                bank_sel_q, bank_sel_d;
  logic                have_frame_q, have_frame_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [DCNT_W-1:0]   decay_cnt_q, decay_cnt_d;
  logic                decay_pend_q, decay_pend_d;
  logic                frame_decay_q, frame_decay_d;
  logic                s1_we_q, s1_we_d;
  logic [ADDR_W-1:0]   s1_addr_q, s1_addr_d;
  logic                s2_we_q, s2_we_d;
  logic [ADDR_W-1:0]   s2_addr_q, s2_addr_d;
  logic [BAR_W-1:0]    s2_height_q, s2_height_d;
  logic                sweep_q, sweep_d;
  logic [ADDR_W-1:0]   sweep_addr_q, sweep_addr_d;
  logic                rd_gate_q, rd_gate_d;

  logic                take;
  logic                mode_now;
  logic                decay_wrap;
  logic [IDX_W-1:0]    take_idx;
  logic [BAR_W-1:0]    calc_height;

  logic [BAR_W-1:0]    bank_mem      [2*N_BINS];
  logic [BAR_W-1:0]    peak_mem      [N_BINS];
  logic [BAR_W-1:0]    peak_disp_mem [N_BINS];
  logic [BAR_W-1:0]    bank_rd_q, peak_rd_q, peak_disp_rd_q;
  logic                peak_we;
  logic [ADDR_W-1:0]   peak_waddr;
  logic [BAR_W-1:0]    peak_wdata, peak_old;

  spec_height_calc #(
    .DATA_W    (DATA_W),
    .BAR_W     (BAR_W),
    .MAX_H     (MAX_H),
    .LIN_SHIFT (LIN_SHIFT),
    .LOG_GAIN  (LOG_GAIN)
  ) u_height_calc (
    .sys_clk    (sys_clk),
    .sys_rstn   (sys_rstn),
    .in_data    (bus.fft_data),
    .in_log     (mode_now),
    .out_height (calc_height)
  );

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    log_d         = log_q;
    err_d         = 1'b0;
    done_d        = 1'b0;
    commit_d      = 1'b0;
    bank_sel_d    = bank_sel_q;
    have_frame_d  = have_frame_q;
    cnt_d         = cnt_q;
    decay_cnt_d   = decay_cnt_q;
    decay_pend_d  = decay_pend_q;
    frame_decay_d = frame_decay_q;
    sweep_d       = sweep_q;
    sweep_addr_d  = sweep_addr_q;
    rd_gate_d     = rd_gate_q;
    take          = 1'b0;
    take_idx      = idx_q;
    mode_now      = log_q;

    // Commit runs one cycle after DONE so the swap lines up with the last write.
    decay_wrap = commit_q && (decay_cnt_q == DCNT_W'(DECAY_FRAMES - 1));
    if (commit_q) begin
      bank_sel_d   = ~bank_sel_q;
      have_frame_d = 1'b1;
      done_d       = 1'b1;
      cnt_d        = cnt_q + 16'd1;
      decay_cnt_d  = decay_wrap ? '0 : decay_cnt_q + 1'b1;
      if (decay_wrap) decay_pend_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (bus.fft_valid && bus.fft_sop && !sweep_q) begin
          state_d       = CAPTURE;
          take          = 1'b1;
          take_idx      = '0;
          idx_d         = IDX_W'(1);
          log_d         = log_mode;
          mode_now      = log_mode;
          frame_decay_d = decay_pend_q | decay_wrap;
          decay_pend_d  = 1'b0;
        end
      end
      CAPTURE: begin
        if (bus.fft_valid) begin
          take = 1'b1;
          if (bus.fft_sop) begin
            err_d    = 1'b1;
            take_idx = '0;
            idx_d    = IDX_W'(1);
            log_d    = log_mode;
            mode_now = log_mode;
          end else if (idx_q == '1) begin
            state_d = bus.fft_eop ? DONE : IDLE;
            err_d   = !bus.fft_eop;
          end else if (bus.fft_eop) begin
            state_d = IDLE;
            err_d   = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d  = IDLE;
        commit_d = !freeze;
      end
      default: state_d = IDLE;
    endcase

    s1_we_d     = take && (take_idx[IDX_W-1:ADDR_W] == '0);
    s1_addr_d   = take_idx[ADDR_W-1:0];
    s2_we_d     = s1_we_q;
    s2_addr_d   = s1_addr_q;
    s2_height_d = calc_height;

    if (sweep_q) begin
      sweep_addr_d = sweep_addr_q + 1'b1;
      if (sweep_addr_q == '1) sweep_d = 1'b0;
    end

    if (bus.rd_en) rd_gate_d = have_frame_q;
  end

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      log_q         <= 1'b0;
      err_q         <= 1'b0;
      done_q        <= 1'b0;
      commit_q      <= 1'b0;
      bank_sel_q    <= 1'b0;
      have_frame_q  <= 1'b0;
      cnt_q         <= '0;
      decay_cnt_q   <= '0;
      decay_pend_q  <= 1'b0;
      frame_decay_q <= 1'b0;
      s1_we_q       <= 1'b0;
      s1_addr_q     <= '0;
      s2_we_q       <= 1'b0;
      s2_addr_q     <= '0;
      s2_height_q   <= '0;
      sweep_q       <= 1'b1;
      sweep_addr_q  <= '0;
      rd_gate_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      log_q         <= log_d;
      err_q         <= err_d;
      done_q        <= done_d;
      commit_q      <= commit_d;
      bank_sel_q    <= bank_sel_d;
      have_frame_q  <= have_frame_d;
      cnt_q         <= cnt_d;
      decay_cnt_q   <= decay_cnt_d;
      decay_pend_q  <= decay_pend_d;
      frame_decay_q <= frame_decay_d;
      s1_we_q       <= s1_we_d;
      s1_addr_q     <= s1_addr_d;
      s2_we_q       <= s2_we_d;
      s2_addr_q     <= s2_addr_d;
      s2_height_q   <= s2_height_d;
      sweep_q       <= sweep_d;
      sweep_addr_q  <= sweep_addr_d;
      rd_gate_q     <= rd_gate_d;
    end
  end

  // The peak array is duplicated so the RMW port and the display port each get a read.
  always_comb begin
    if (frame_decay_q) begin
      peak_old = (peak_rd_q < BAR_W'(DECAY_STEP)) ? '0 : peak_rd_q - BAR_W'(DECAY_STEP);
    end else begin
      peak_old = peak_rd_q;
    end
    if (sweep_q) begin
      peak_we    = 1'b1;
      peak_waddr = sweep_addr_q;
      peak_wdata = '0;
    end else begin
      peak_we    = s2_we_q && !freeze;
      peak_waddr = s2_addr_q;
      peak_wdata = (peak_old > s2_height_q) ? peak_old : s2_height_q;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (s2_we_q) bank_mem[{~bank_sel_q, s2_addr_q}] <= s2_height_q;
    if (peak_we) begin
      peak_mem[peak_waddr]      <= peak_wdata;
      peak_disp_mem[peak_waddr] <= peak_wdata;
    end
    peak_rd_q <= peak_mem[s1_addr_q];
    if (bus.rd_en) begin
      bank_rd_q      <= bank_mem[{bank_sel_q, bus.rd_addr}];
      peak_disp_rd_q <= peak_disp_mem[bus.rd_addr];
    end
  end

  assign bus.rd_data = rd_gate_q ? bank_rd_q      : '0;
  assign bus.rd_peak = rd_gate_q ? peak_disp_rd_q : '0;
  assign frame_done  = done_q;
  assign frame_err   = err_q;
  assign frame_cnt   = cnt_q;

endmodule

// File: tb/tb_spectrum_frame_buffer.sv
// Directed bench for spectrum_frame_buffer: linear/log scaling, peak decay,
// malformed frames, freeze and reset mid-capture.
module tb_spectrum_frame_buffer;

  logic        sys_clk  = 1'b0;
  logic        sys_rstn = 1'b0;
  logic        log_mode = 1'b0;
  logic        freeze   = 1'b0;
  logic        frame_done;
  logic        frame_err;
  logic [15:0] frame_cnt;

  int vectors     = 0;
  int miscompares = 0;
  int done_seen   = 0;
  int err_seen    = 0;

  spectrum_frame_buffer_if #(.DATA_W(32), .ADDR_W(9), .BAR_W(11)) bus ();

  spectrum_frame_buffer dut (
    .sys_clk    (sys_clk),
    .sys_rstn   (sys_rstn),
    .log_mode   (log_mode),
    .freeze     (freeze),
    .bus        (bus),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .frame_cnt  (frame_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) begin
    if (frame_done) done_seen++;
    if (frame_err)  err_seen++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input int observed, input int expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
    $display("vec %0d %s observed=%0d expected=%0d", vectors, tag, observed, expected);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  // pat 0: ramp k<<12 (upper half saturates if wrongly stored); 1: log probes;
  // 2: bin 3 = v<<12, rest 0; 3: every bin v<<12.
  function automatic logic [31:0] bin_val(input int pat, input int v, input int k);
    case (pat)
      0: return (k < 512) ? 32'(k << 12) : 32'h003F_F000;
      1: begin
        if (k == 5) return 32'h0000_0400;
        if (k == 6) return 32'h0000_0000;
        if (k == 7) return 32'hFFFF_FFFF;
        return 32'h0000_0001;
      end
      2: return (k == 3) ? 32'(v << 12) : 32'h0;
      default: return 32'(v << 12);
    endcase
  endfunction

  task automatic send_beats(input int pat, input int v, input int first_k, input int last_k,
                            input bit sop_first, input bit eop_last);
    for (int k = first_k; k <= last_k; k++) begin
      if (k % 97 == 50) begin
        bus.fft_valid = 1'b0;
        @(negedge sys_clk);
      end
      bus.fft_valid = 1'b1;
      bus.fft_sop   = sop_first && (k == first_k);
      bus.fft_eop   = eop_last && (k == last_k);
      bus.fft_data  = bin_val(pat, v, k);
      @(negedge sys_clk);
    end
    bus.fft_valid = 1'b0;
    bus.fft_sop   = 1'b0;
    bus.fft_eop   = 1'b0;
  endtask

  task automatic full_frame(input int pat, input int v);
    send_beats(pat, v, 0, 1023, 1'b1, 1'b1);
    tick(4);
  endtask

  task automatic do_read(input int addr, output int data, output int peak);
    bus.rd_addr = 9'(addr);
    bus.rd_en   = 1'b1;
    @(negedge sys_clk);
    bus.rd_en   = 1'b0;
    data = int'(bus.rd_data);
    peak = int'(bus.rd_peak);
  endtask

  task automatic apply_reset();
    sys_rstn = 1'b0;
    tick(3);
    sys_rstn = 1'b1;
    tick(520);
  endtask

  initial begin
    int d;
    int p;
    int done0;
    bus.fft_sop = 1'b0; bus.fft_eop = 1'b0; bus.fft_valid = 1'b0;
    bus.fft_data = '0; bus.rd_addr = '0; bus.rd_en = 1'b0;

    // Reset state
    tick(3);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_frame_err", int'(frame_err), 0);
    check("rst_frame_cnt", int'(frame_cnt), 0);
    sys_rstn = 1'b1;
    tick(520);
    do_read(10, d, p);
    check("rst_rd_data", d, 0);
    check("rst_rd_peak", p, 0);

    // Linear ramp frame, with exact frame_done latency
    send_beats(0, 0, 0, 1023, 1'b1, 1'b1);
    check("done_lat_c1", int'(frame_done), 0);
    tick(1);
    check("done_lat_c2", int'(frame_done), 0);
    tick(1);
    check("done_lat_c3", int'(frame_done), 1);
    check("ramp_cnt", int'(frame_cnt), 1);
    tick(1);
    check("done_one_cycle", int'(frame_done), 0);
    do_read(100, d, p);
    check("ramp_rd100", d, 100);
    check("ramp_pk100", p, 100);
    bus.rd_addr = 9'd200;
    tick(1);
    check("ramp_hold", int'(bus.rd_data), 100);
    do_read(511, d, p);
    check("ramp_rd511", d, 511);
    do_read(0, d, p);
    check("ramp_rd0", d, 0);

    // Log scaling
    log_mode = 1'b1;
    full_frame(1, 0);
    log_mode = 1'b0;
    check("log_cnt", int'(frame_cnt), 2);
    do_read(5, d, p);
    check("log_rd5", d, 242);
    do_read(6, d, p);
    check("log_rd6", d, 0);
    do_read(7, d, p);
    check("log_rd7_allones", d, 704);
    check("log_pk7", p, 704);
    do_read(8, d, p);
    check("log_rd8_one", d, 22);

    // Malformed: short eop, then sop mid-frame
    done0 = done_seen;
    send_beats(0, 0, 0, 700, 1'b1, 1'b1);
    tick(2);
    check("short_eop_err", err_seen, 1);
    send_beats(0, 0, 0, 399, 1'b1, 1'b0);
    send_beats(0, 0, 0, 9, 1'b1, 1'b0);
    tick(2);
    check("mid_sop_err", err_seen, 2);
    check("malformed_no_done", done_seen - done0, 0);
    check("malformed_cnt", int'(frame_cnt), 2);
    do_read(5, d, p);
    check("malformed_bank_kept", d, 242);
    send_beats(0, 0, 10, 1023, 1'b0, 1'b1);
    tick(4);
    check("restart_cnt", int'(frame_cnt), 3);
    do_read(100, d, p);
    check("restart_rd100", d, 100);

    // Freeze across two frames, then release
    freeze = 1'b1;
    done0 = done_seen;
    full_frame(3, 700);
    full_frame(3, 700);
    check("freeze_no_done", done_seen - done0, 0);
    check("freeze_cnt", int'(frame_cnt), 3);
    do_read(100, d, p);
    check("freeze_rd100", d, 100);
    check("freeze_pk100", p, 100);
    freeze = 1'b0;
    tick(2);
    full_frame(3, 700);
    check("unfreeze_cnt", int'(frame_cnt), 4);
    do_read(100, d, p);
    check("unfreeze_rd100", d, 700);
    check("unfreeze_pk100", p, 700);

    // Reset mid-capture
    send_beats(3, 300, 0, 299, 1'b1, 1'b0);
    sys_rstn = 1'b0;
    tick(1);
    check("midrst_cnt", int'(frame_cnt), 0);
    check("midrst_rd_data", int'(bus.rd_data), 0);
    check("midrst_done", int'(frame_done), 0);
    tick(2);
    sys_rstn = 1'b1;
    tick(520);
    do_read(100, d, p);
    check("midrst_rd100", d, 0);
    check("midrst_pk100", p, 0);

    // Peak hold with decay every 4 accepted frames
    full_frame(2, 600);
    do_read(3, d, p);
    check("peak_a_rd3", d, 600);
    check("peak_a_pk3", p, 600);
    full_frame(2, 0);
    full_frame(2, 0);
    full_frame(2, 0);
    do_read(3, d, p);
    check("peak_f4_rd3", d, 0);
    check("peak_f4_pk3", p, 600);
    full_frame(2, 0);
    do_read(3, d, p);
    check("peak_decay_pk3", p, 592);

    // Decay clamps at zero
    apply_reset();
    full_frame(2, 5);
    full_frame(2, 0);
    full_frame(2, 0);
    full_frame(2, 0);
    do_read(3, d, p);
    check("sat0_before_pk3", p, 5);
    full_frame(2, 0);
    do_read(3, d, p);
    check("sat0_after_pk3", p, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
